// File: rtl/vc_mem_net_client_adapter_pkg.sv
// Shared sizing helpers for the client-side memory/network adapter.
// Message layouts (MSB first):
//   memreq  : {type, addr, len, data}
//   memresp : {type, len, data}
//   net msg : {dest, src, payload}
package vc_mem_net_client_adapter_pkg;

    localparam int  MEM_TYPE_SZ = 1;
    localparam logic MEM_TYPE_RD = 1'b0;
    localparam logic MEM_TYPE_WR = 1'b1;

    // Byte-length field; a single-byte data word still keeps a 1-bit len.
    function automatic int mem_len_sz(input int data_sz);
        return (data_sz <= 8) ? 1 : $clog2(data_sz / 8);
    endfunction

    function automatic int memreq_msg_sz(input int addr_sz, input int data_sz);
        return MEM_TYPE_SZ + addr_sz + mem_len_sz(data_sz) + data_sz;
    endfunction

    function automatic int memresp_msg_sz(input int data_sz);
        return MEM_TYPE_SZ + mem_len_sz(data_sz) + data_sz;
    endfunction

    function automatic int net_msg_sz(input int num_nodes, input int payload_sz);
        return 2 * $clog2(num_nodes) + payload_sz;
    endfunction

endpackage

// File: rtl/vc_mem_net_client_adapter_queue.sv
// Two-entry val/rdy queue with registered full/empty flags.
// Ports: clk, reset_n (async, active low); enq_val/enq_rdy/enq_msg in;
//        deq_val/deq_rdy/deq_msg out.
// enq_rdy depends only on the registered full flag, so a full queue only
// accepts again in the cycle after a dequeue (no rdy-to-rdy comb path).
module vc_queue_2entry
    import vc_mem_net_client_adapter_pkg::*;
#(
    parameter int p_width = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_msg
);

    logic [p_width-1:0] slot [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               full;
    logic               empty;
    logic               enq;
    logic               deq;

    assign enq_rdy = ~full;
    assign deq_val = ~empty;
    assign deq_msg = slot[rd_ptr];
    assign enq     = enq_val & ~full;
    assign deq     = deq_rdy & ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            // Occupancy only moves when exactly one side fires.
            if (enq && !deq) begin
                empty <= 1'b0;
                full  <= (~wr_ptr == rd_ptr);
            end else if (deq && !enq) begin
                full  <= 1'b0;
                empty <= (wr_ptr == ~rd_ptr);
            end
        end
    end

    // Payload storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (enq) slot[wr_ptr] <= enq_msg;
    end

endmodule

// File: rtl/vc_mem_net_client_adapter.sv
// Client-side memory-to-network bridge.
// Request path : memreq -> 2-entry queue -> netout {dest, src, memreq}.
//                dest is the bank-select field of the address.
// Response path: netin -> 2-entry queue -> memresp (dest/src stripped).
// Ports: clk, reset_n (async, active low); memreq_*, netout_*, netin_*,
//        memresp_* val/rdy channels; outstanding = in-flight count;
//        err = sticky flag for misrouted or unsolicited responses.
module vc_mem_net_client_adapter
    import vc_mem_net_client_adapter_pkg::*;
#(
    parameter  int p_num_nodes       = 4,
    parameter  int p_addr_sz         = 16,
    parameter  int p_data_sz         = 32,
    parameter  int p_src_id          = 0,
    parameter  int p_bank_lsb        = 2,
    parameter  int p_max_outstanding = 4,
    localparam int c_srcdest_sz      = $clog2(p_num_nodes),
    localparam int c_len_sz          = mem_len_sz(p_data_sz),
    localparam int c_memreq_sz       = memreq_msg_sz(p_addr_sz, p_data_sz),
    localparam int c_memresp_sz      = memresp_msg_sz(p_data_sz),
    localparam int c_netreq_sz       = net_msg_sz(p_num_nodes, c_memreq_sz),
    localparam int c_netresp_sz      = net_msg_sz(p_num_nodes, c_memresp_sz),
    localparam int c_cnt_sz          = $clog2(p_max_outstanding + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [c_memreq_sz-1:0]  memreq_msg,
    input  logic                    memreq_val,
    output logic                    memreq_rdy,
    output logic [c_netreq_sz-1:0]  netout_msg,
    output logic                    netout_val,
    input  logic                    netout_rdy,
    input  logic [c_netresp_sz-1:0] netin_msg,
    input  logic                    netin_val,
    output logic                    netin_rdy,
    output logic [c_memresp_sz-1:0] memresp_msg,
    output logic                    memresp_val,
    input  logic                    memresp_rdy,
    output logic [c_cnt_sz-1:0]     outstanding,
    output logic                    err
);

    localparam logic [c_srcdest_sz-1:0] c_src_id  = c_srcdest_sz'(p_src_id);
    localparam logic [c_cnt_sz-1:0]     c_max_out = c_cnt_sz'(p_max_outstanding);

    // Bank-select bit position inside the packed memreq message.
    localparam int c_dest_pos = p_data_sz + c_len_sz + p_bank_lsb;

    logic                    live;       // low in reset, high from first edge after
    logic                    credit_ok;
    logic                    req_enq_rdy;
    logic                    resp_enq_rdy;
    logic                    req_fire;
    logic                    resp_fire;
    logic                    netin_fire;
    logic                    dest_bad;
    logic [c_srcdest_sz-1:0] req_dest;
    logic [c_netreq_sz-1:0]  req_net;
    logic [c_netresp_sz-1:0] resp_head;
    logic                    resp_hdr_unused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) live <= 1'b0;
        else          live <= 1'b1;
    end

    assign credit_ok  = (outstanding < c_max_out);
    assign memreq_rdy = live & req_enq_rdy & credit_ok;
    assign netin_rdy  = live & resp_enq_rdy;

    assign req_fire   = memreq_val & memreq_rdy;
    assign netin_fire = netin_val & netin_rdy;
    assign resp_fire  = memresp_val & memresp_rdy;

    // Address bits above the bank field are ignored, so banks wrap.
    assign req_dest = memreq_msg[c_dest_pos +: c_srcdest_sz];
    assign req_net  = {req_dest, c_src_id, memreq_msg};

    assign dest_bad = (netin_msg[c_memresp_sz + c_srcdest_sz +: c_srcdest_sz] != c_src_id);

    vc_queue_2entry #(.p_width(c_netreq_sz)) u_req_q (
        .clk     (clk),
        .reset_n (reset_n),
        .enq_val (memreq_val & live & credit_ok),
        .enq_rdy (req_enq_rdy),
        .enq_msg (req_net),
        .deq_val (netout_val),
        .deq_rdy (netout_rdy),
        .deq_msg (netout_msg)
    );

    vc_queue_2entry #(.p_width(c_netresp_sz)) u_resp_q (
        .clk     (clk),
        .reset_n (reset_n),
        .enq_val (netin_val & live),
        .enq_rdy (resp_enq_rdy),
        .enq_msg (netin_msg),
        .deq_val (memresp_val),
        .deq_rdy (memresp_rdy),
        .deq_msg (resp_head)
    );

    assign memresp_msg     = resp_head[c_memresp_sz-1:0];
    // Routing header is checked on arrival, not at delivery.
    assign resp_hdr_unused = ^resp_head[c_memresp_sz +: 2*c_srcdest_sz];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (req_fire && !resp_fire)
                outstanding <= outstanding + c_cnt_sz'(1);
            else if (resp_fire && !req_fire && outstanding != '0)
                outstanding <= outstanding - c_cnt_sz'(1);
            // Misrouted arrivals are still forwarded; only the flag records them.
            if ((netin_fire && dest_bad) || (resp_fire && outstanding == '0))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_mem_net_client_adapter.sv
module tb_vc_mem_net_client_adapter;

    localparam int NREQ  = 55;   // {dest2, src2, type1, addr16, len2, data32}
    localparam int NRESP = 39;   // {dest2, src2, type1, len2, data32}
    localparam int REQ   = 51;
    localparam int RESP  = 35;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [REQ-1:0]   memreq_msg = '0;
    logic             memreq_val = 1'b0;
    logic             memreq_rdy;
    logic [NREQ-1:0]  netout_msg;
    logic             netout_val;
    logic             netout_rdy = 1'b0;
    logic [NRESP-1:0] netin_msg = '0;
    logic             netin_val = 1'b0;
    logic             netin_rdy;
    logic [RESP-1:0]  memresp_msg;
    logic             memresp_val;
    logic             memresp_rdy = 1'b0;
    logic [2:0]       outstanding;
    logic             err;

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0] exp_net[$];
    logic [RESP-1:0] exp_resp[$];

    vc_mem_net_client_adapter #(
        .p_num_nodes(4), .p_addr_sz(16), .p_data_sz(32), .p_src_id(1),
        .p_bank_lsb(2), .p_max_outstanding(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .netout_msg(netout_msg), .netout_val(netout_val), .netout_rdy(netout_rdy),
        .netin_msg(netin_msg), .netin_val(netin_val), .netin_rdy(netin_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitors: inputs only change just after posedge, so at
    // negedge val & rdy tells exactly what fires on the coming edge.
    always @(negedge clk) begin : mon_net
        logic [NREQ-1:0] e;
        if (reset_n && netout_val && netout_rdy) begin
            checks++;
            if (exp_net.size() == 0) begin
                errors++;
                $display("FAIL netout_unexpected got=%h", netout_msg);
            end else begin
                e = exp_net.pop_front();
                if (netout_msg !== e) begin
                    errors++;
                    $display("FAIL netout_msg got=%h exp=%h", netout_msg, e);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_resp
        logic [RESP-1:0] e;
        if (reset_n && memresp_val && memresp_rdy) begin
            checks++;
            if (exp_resp.size() == 0) begin
                errors++;
                $display("FAIL memresp_unexpected got=%h", memresp_msg);
            end else begin
                e = exp_resp.pop_front();
                if (memresp_msg !== e) begin
                    errors++;
                    $display("FAIL memresp_msg got=%h exp=%h", memresp_msg, e);
                end
            end
        end
    end

    // All helpers start and end at posedge+1.
    task automatic send_req(input logic t, input logic [15:0] a, input logic [31:0] d);
        bit done = 0;
        memreq_msg = {t, a, 2'd0, d};
        memreq_val = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (memreq_rdy) begin
                exp_net.push_back({a[3:2], 2'd1, t, a, 2'd0, d});
                done = 1;
            end
            @(posedge clk); #1;
        end
        memreq_val = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_req_timeout addr=%h got=rdy0 exp=rdy1", a);
        end
    endtask

    task automatic send_resp(input logic [1:0] dst, input logic [1:0] src,
                             input logic t, input logic [31:0] d);
        bit done = 0;
        netin_msg = {dst, src, t, 2'd0, d};
        netin_val = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (netin_rdy) begin
                exp_resp.push_back({t, 2'd0, d});
                done = 1;
            end
            @(posedge clk); #1;
        end
        netin_val = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_resp_timeout data=%h got=rdy0 exp=rdy1", d);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && (exp_net.size() != 0 || exp_resp.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_net.size() != 0 || exp_resp.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got net=%0d resp=%0d exp=0", exp_net.size(), exp_resp.size());
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (outstanding !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got out=%0d err=%b exp out=0 err=0", name, outstanding, err);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        exp_net.delete();
        exp_resp.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({memreq_rdy, netin_rdy, netout_val, memresp_val, err} !== 5'b0 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b%b val=%b%b err=%b out=%0d exp all 0",
                     memreq_rdy, netin_rdy, netout_val, memresp_val, err, outstanding);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (memreq_rdy !== 1'b0 || netin_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_edge got=%b%b exp=00", memreq_rdy, netin_rdy);
        end
        @(posedge clk); #1;
        checks++;
        if (memreq_rdy !== 1'b1 || netin_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_edge got=%b%b exp=11", memreq_rdy, netin_rdy);
        end
    endtask

    task automatic test_routing();
        logic [15:0] addrs [4] = '{16'h0004, 16'h0008, 16'h000c, 16'h0010};
        logic [1:0]  dests [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        netout_rdy  = 1'b1;
        memresp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_req(WR, addrs[i], 32'h0a0b0c0d + i);
            checks++;
            if (netout_val !== 1'b1 || netout_msg[54:53] !== dests[i] || netout_msg[52:51] !== 2'd1) begin
                errors++;
                $display("FAIL route_%0d got val=%b dest=%0d src=%0d exp val=1 dest=%0d src=1",
                         i, netout_val, netout_msg[54:53], netout_msg[52:51], dests[i]);
            end
        end
        for (int i = 0; i < 4; i++) send_resp(2'd1, dests[i], WR, 32'h0);
        wait_drain();
        check_idle("routing");
    endtask

    task automatic test_credit();
        for (int i = 0; i < 4; i++) send_req(RD, 16'h0020 + 16'(4*i), 32'h0);
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd4 || memreq_rdy !== 1'b0) begin
            errors++;
            $display("FAIL credit_full got out=%0d rdy=%b exp out=4 rdy=0", outstanding, memreq_rdy);
        end
        @(posedge clk); #1;
        send_resp(2'd1, 2'd0, RD, 32'h1111);
        @(posedge clk); #1;
        checks++;
        if (outstanding !== 3'd3 || memreq_rdy !== 1'b1) begin
            errors++;
            $display("FAIL credit_release got out=%0d rdy=%b exp out=3 rdy=1", outstanding, memreq_rdy);
        end
        // Buffer one response, then let it fire together with a request.
        memresp_rdy = 1'b0;
        send_resp(2'd1, 2'd1, RD, 32'h2222);
        memreq_msg  = {RD, 16'h0030, 2'd0, 32'h0};
        memreq_val  = 1'b1;
        memresp_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (memreq_rdy !== 1'b1 || memresp_val !== 1'b1) begin
            errors++;
            $display("FAIL simul_setup got rdy=%b rval=%b exp 1 1", memreq_rdy, memresp_val);
        end else begin
            exp_net.push_back({2'd0, 2'd1, RD, 16'h0030, 2'd0, 32'h0});
        end
        @(posedge clk); #1 memreq_val = 1'b0;
        checks++;
        if (outstanding !== 3'd3) begin
            errors++;
            $display("FAIL simul_count got=%0d exp=3", outstanding);
        end
        for (int i = 0; i < 3; i++) send_resp(2'd1, 2'd2, RD, 32'h3000 + i);
        wait_drain();
        check_idle("credit");
    endtask

    task automatic test_unwrap();
        send_req(RD, 16'h0004, 32'h0);
        send_resp(2'd1, 2'd2, RD, 32'h0e0f0102);
        checks++;
        if (memresp_val !== 1'b1 || memresp_msg !== {RD, 2'd0, 32'h0e0f0102} || err !== 1'b0) begin
            errors++;
            $display("FAIL unwrap got val=%b msg=%h err=%b exp val=1 msg=%h err=0",
                     memresp_val, memresp_msg, err, {RD, 2'd0, 32'h0e0f0102});
        end
        wait_drain();
        check_idle("unwrap");
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 3; i++) send_req(RD, 16'h0040, 32'h0);
        memresp_rdy = 1'b0;
        send_resp(2'd1, 2'd0, RD, 32'haaaa0001);
        send_resp(2'd1, 2'd0, RD, 32'haaaa0002);
        netin_msg = {2'd1, 2'd0, RD, 2'd0, 32'haaaa0003};
        netin_val = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (netin_rdy !== 1'b0 || memresp_val !== 1'b1) begin
                errors++;
                $display("FAIL bp_full_%0d got rdy=%b val=%b exp rdy=0 val=1", i, netin_rdy, memresp_val);
            end
            @(posedge clk); #1;
        end
        netin_val   = 1'b0;
        memresp_rdy = 1'b1;
        send_resp(2'd1, 2'd0, RD, 32'haaaa0003);
        wait_drain();
        check_idle("back_pressure");
    endtask

    task automatic test_unsolicited();
        send_resp(2'd1, 2'd0, RD, 32'hdead0001);
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL unsolicited got err=%b out=%0d exp err=1 out=0", err, outstanding);
        end
        wait_drain();
        apply_reset();
        check_idle("after_reset");
    endtask

    task automatic test_misroute();
        send_req(RD, 16'h0008, 32'h0);
        send_resp(2'd3, 2'd2, RD, 32'hbeef0003);
        checks++;
        if (err !== 1'b1 || memresp_val !== 1'b1) begin
            errors++;
            $display("FAIL misroute got err=%b val=%b exp err=1 val=1", err, memresp_val);
        end
        wait_drain();
        checks++;
        if (outstanding !== 3'd0) begin
            errors++;
            $display("FAIL misroute_count got=%0d exp=0", outstanding);
        end
    endtask

    task automatic test_reset_midstream();
        netout_rdy = 1'b0;
        send_req(WR, 16'h0004, 32'h1);
        send_req(WR, 16'h0008, 32'h2);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (netout_val !== 1'b0 || outstanding !== 3'd0 || err !== 1'b0 || memreq_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got val=%b out=%0d err=%b rdy=%b exp 0 0 0 0",
                     netout_val, outstanding, err, memreq_rdy);
        end
        exp_net.delete();
        exp_resp.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1 netout_rdy = 1'b1;
        send_req(WR, 16'h000c, 32'h5a5a5a5a);
        send_resp(2'd1, 2'd3, WR, 32'h0);
        wait_drain();
        check_idle("resume");
    endtask

    initial begin
        test_reset();
        test_routing();
        test_credit();
        test_unwrap();
        test_back_pressure();
        test_unsolicited();
        test_misroute();
        test_reset_midstream();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
